// File: rtl/adder_pkg.sv
// Shared types and sizing for the pipelined adder.
// The stage record travels down the register chain.
package adder_pkg;

  localparam int unsigned ADD_W = 16;
  localparam int unsigned ADD_S = 4;

  function automatic int unsigned chunk_w(
    input int unsigned w,
    input int unsigned s
  );
    return w / s;
  endfunction

  localparam int unsigned ADD_C = chunk_w(ADD_W, ADD_S);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [ADD_W-1:0] sum_lo;
    logic [ADD_W-1:0] a_hi;
    logic [ADD_W-1:0] b_hi;
    logic             a_msb;
    logic             b_msb;
  } stage_t;

endpackage

// File: rtl/adder_stage.sv
// One chunk of the carry chain plus its pipeline register.
// Loads whenever it is empty or downstream is taking its contents.
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned K = 0,
  parameter int unsigned C = ADD_C
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t i_rec,
  input  logic   i_ready,
  output logic   o_ready,
  output stage_t o_rec
);

  stage_t     r_rec;
  stage_t     w_nxt;
  logic [C:0] w_add;

  assign w_add = {1'b0, i_rec.a_hi[K*C +: C]}
               + {1'b0, i_rec.b_hi[K*C +: C]}
               + {{C{1'b0}}, i_rec.carry};

  always_comb begin
    w_nxt = i_rec;
    w_nxt.sum_lo[K*C +: C] = w_add[C-1:0];
    w_nxt.carry = w_add[C];
  end

  assign o_ready = !r_rec.valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rec <= '0;
    end else if (o_ready) begin
      r_rec <= w_nxt;
    end
  end

  assign o_rec = r_rec;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor with valid/ready on both sides.
// Operand inversion and stage-0 carry here; chunks in adder_stage.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = ADD_W,
  parameter int unsigned STAGES = ADD_S
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned C = chunk_w(WIDTH, STAGES);

  if (STAGES == 0 || WIDTH % STAGES != 0 || WIDTH != ADD_W) begin : g_bad
    $error("pipelined_adder: bad WIDTH/STAGES");
  end

  stage_t           w_in;
  stage_t           w_rec [STAGES];
  stage_t           w_last;
  logic [STAGES:0]  w_rdy;
  logic [WIDTH-1:0] w_b;
  logic             w_unused;

  assign w_b = sub ? ~b : b;

  always_comb begin
    w_in        = '0;
    w_in.valid  = in_valid;
    w_in.carry  = sub ? 1'b1 : cin;
    w_in.a_hi   = a;
    w_in.b_hi   = w_b;
    w_in.a_msb  = a[WIDTH-1];
    w_in.b_msb  = w_b[WIDTH-1];
  end

  assign w_rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      adder_stage #(.K(k), .C(C)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_rec   (w_in),
        .i_ready (w_rdy[k+1]),
        .o_ready (w_rdy[k]),
        .o_rec   (w_rec[k])
      );
    end else begin : g_next
      adder_stage #(.K(k), .C(C)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_rec   (w_rec[k-1]),
        .i_ready (w_rdy[k+1]),
        .o_ready (w_rdy[k]),
        .o_rec   (w_rec[k])
      );
    end
  end

  assign w_last    = w_rec[STAGES-1];
  assign in_ready  = w_rdy[0];
  assign out_valid = w_last.valid;
  assign sum       = w_last.sum_lo;
  assign cout      = w_last.carry;
  assign ovf       = (w_last.a_msb == w_last.b_msb)
                  && (w_last.sum_lo[WIDTH-1] != w_last.a_msb);

  // Operand bits are fully consumed by the last stage.
  assign w_unused = ^{w_last.a_hi, w_last.b_hi};

endmodule
